tick_divider_multi: RTL and testbench

//   Multi-channel programmable clock-enable generator. Successor to the fixed
//   1 Hz toggle divider. Each channel divides clk by a runtime-loadable period.

---
 rtl/tick_divider_multi.sv | 120 ++++++++++++
 tb/tb_tick_divider_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_multi.sv
// Multi-channel programmable clock-enable generator: per-channel one-cycle tick
// and near-50% square wave, all in the clk domain with runtime-loadable periods.
module tick_divider_multi #(
  parameter int          NCH     = 4,
  parameter int          CW      = 32,
  parameter int          CHW     = 2,
  parameter int unsigned DEF_DIV = 100_000_000
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] en,
  input  logic           clr,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] busy
);

  localparam logic [CW-1:0] MIN_DIV = CW'(2);
  localparam logic [CW-1:0] DEF_RAW = CW'(DEF_DIV);
  localparam logic [CW-1:0] DEF_P   = (DEF_RAW < MIN_DIV) ? MIN_DIV : DEF_RAW;

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  div_q  [NCH];
  logic [CW-1:0]  div_d  [NCH];
  logic [CW-1:0]  pend_q [NCH];
  logic [CW-1:0]  pend_d [NCH];
  logic [CW-1:0]  cfg_p;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] tick_d;
  logic [NCH-1:0] sq_d;
  logic [NCH-1:0] busy_d;

  // Out-of-range channel numbers never match any i, so such writes are dropped.
  always_comb begin
    cfg_p = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = cfg_we && (int'(cfg_ch) == i);
      wrap[i] = en[i] && (cnt_q[i] == div_q[i] - CW'(1));
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pend_d[i] = pend_q[i];
      tick_d[i] = 1'b0;
      sq_d[i]   = sq[i];
      busy_d[i] = busy[i];
      if (clr) begin
        cnt_d[i]  = '0;
        sq_d[i]   = 1'b0;
        busy_d[i] = 1'b0;
        if (hit[i]) begin
          div_d[i] = cfg_p;
        end else if (busy[i]) begin
          div_d[i] = pend_q[i];
        end
      end else if (en[i]) begin
        tick_d[i] = wrap[i];
        if (wrap[i]) begin
          cnt_d[i] = '0;
          sq_d[i]  = 1'b1;
          if (busy[i]) begin
            div_d[i]  = pend_q[i];
            busy_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          if (cnt_q[i] + CW'(1) == (div_q[i] >> 1)) begin
            sq_d[i] = 1'b0;
          end
        end
        // A write landing on a wrap edge is deferred to the following wrap.
        if (hit[i]) begin
          pend_d[i] = cfg_p;
          busy_d[i] = 1'b1;
        end
      end else begin
        if (hit[i]) begin
          div_d[i]  = cfg_p;
          cnt_d[i]  = '0;
          busy_d[i] = 1'b0;
        end else if (busy[i]) begin
          div_d[i]  = pend_q[i];
          cnt_d[i]  = '0;
          busy_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DEF_P;
        pend_q[i] <= '0;
      end
      tick <= '0;
      sq   <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
      end
      tick <= tick_d;
      sq   <= sq_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_tick_divider_multi.sv
// Directed bench for tick_divider_multi (NCH=4, CW=16, CHW=3, DEF_DIV=10).
// Inputs change and outputs are sampled on the falling edge; "point k" = after rising edge k.
module tb_tick_divider_multi;

  logic        clk;
  logic        rstn;
  logic [3:0]  en;
  logic        clr;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [3:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  tick_divider_multi #(
    .NCH(4), .CW(16), .CHW(3), .DEF_DIV(10)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tick(tick), .sq(sq), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en_v, input logic clr_v, input logic we_v,
                               input logic [2:0] ch_v, input logic [15:0] div_v);
    en      = en_v;
    clr     = clr_v;
    cfg_we  = we_v;
    cfg_ch  = ch_v;
    cfg_div = div_v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits n edges; channel ch must be silent for n-1 of them and tick on the last.
  task automatic expectPeriod(input int ch, input int n, input string tag, output logic [3:0] seen);
    logic early;
    early = 1'b0;
    seen  = '0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      early = early | tick[ch];
      seen  = seen | tick;
    end
    @(negedge clk);
    seen = seen | tick;
    checkOutput({tag, "_quiet"}, 32'(early), 32'd0);
    checkOutput(tag, 32'(tick[ch]), 32'd1);
  endtask

  logic [3:0] seen;
  logic [3:0] seen_all;
  logic       acc;

  initial begin
    rstn = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0, 16'd0);
    step(2);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_sq",   32'(sq),   32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);

    // point 0
    rstn = 1'b1;
    applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0, 16'd0);
    seen_all = '0;
    expectPeriod(0, 10, "t1_tick10", seen); seen_all |= seen;
    checkOutput("t1_sq_at_wrap", 32'(sq[0]), 32'd1);
    expectPeriod(0, 10, "t1_tick20", seen); seen_all |= seen;
    expectPeriod(0, 10, "t1_tick30", seen); seen_all |= seen;
    checkOutput("t1_others_quiet", 32'(seen_all[3:1]), 32'h0);

    // sq of a P=10 channel: high while cnt is 0..4
    step(4); checkOutput("t2_sq_hi_34", 32'(sq[0]), 32'd1);
    step(1); checkOutput("t2_sq_lo_35", 32'(sq[0]), 32'd0);
    step(4); checkOutput("t2_sq_lo_39", 32'(sq[0]), 32'd0);
    step(1); checkOutput("t2_sq_hi_40", 32'(sq[0]), 32'd1);

    // P=7 to disabled ch1, then enable
    applyStimulus(4'b0001, 1'b0, 1'b1, 3'd1, 16'd7);
    step(1);
    checkOutput("t2_busy_disabled_write", 32'(busy), 32'h0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 3'd0, 16'd0);
    expectPeriod(1, 7, "t2_ch1_tick48", seen);
    step(2); checkOutput("t2_sq1_hi_50", 32'(sq[1]), 32'd1);
    step(1); checkOutput("t2_sq1_lo_51", 32'(sq[1]), 32'd0);
    step(3); checkOutput("t2_sq1_lo_54", 32'(sq[1]), 32'd0);
    step(1); checkOutput("t2_ch1_tick55", 32'(tick[1]), 32'd1);

    // live update of ch0 at cnt=3
    step(5); checkOutput("t3_ch0_tick60", 32'(tick[0]), 32'd1);
    step(3);
    applyStimulus(4'b0011, 1'b0, 1'b1, 3'd0, 16'd4);
    step(1); checkOutput("t3_busy_set", 32'(busy), 32'b0001);
    applyStimulus(4'b0011, 1'b0, 1'b0, 3'd0, 16'd0);
    step(5);
    checkOutput("t3_busy_69", 32'(busy[0]), 32'd1);
    checkOutput("t3_no_tick_69", 32'(tick[0]), 32'd0);
    step(1);
    checkOutput("t3_old_period_tick70", 32'(tick[0]), 32'd1);
    checkOutput("t3_busy_cleared", 32'(busy[0]), 32'd0);
    expectPeriod(0, 4, "t3_tick74", seen);
    expectPeriod(0, 4, "t3_tick78", seen);

    // clamp: P=0 on ch2
    applyStimulus(4'b0011, 1'b0, 1'b1, 3'd2, 16'd0);
    step(1);
    applyStimulus(4'b0111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(1); checkOutput("t4_p0_80", 32'({tick[2], sq[2]}), 32'b00);
    step(1); checkOutput("t4_p0_81", 32'({tick[2], sq[2]}), 32'b11);
    step(1); checkOutput("t4_p0_82", 32'({tick[2], sq[2]}), 32'b00);
    step(1); checkOutput("t4_p0_83", 32'({tick[2], sq[2]}), 32'b11);
    // clamp: P=1 on ch3
    applyStimulus(4'b0111, 1'b0, 1'b1, 3'd3, 16'd1);
    step(1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(2); checkOutput("t4_p1_tick86", 32'(tick[3]), 32'd1);
    step(1); checkOutput("t4_p1_87", 32'({tick[3], sq[3]}), 32'b00);
    step(1); checkOutput("t4_p1_tick88", 32'(tick[3]), 32'd1);
    // write to nonexistent channel 5
    applyStimulus(4'b1111, 1'b0, 1'b1, 3'd5, 16'd3);
    step(1); checkOutput("t4_bad_ch_busy", 32'(busy), 32'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(1); checkOutput("t4_all_tick90", 32'(tick), 32'b1011);

    // pending write on ch1, then clr mid-period
    applyStimulus(4'b1111, 1'b0, 1'b1, 3'd1, 16'd5);
    step(1); checkOutput("t5_pend_busy", 32'(busy), 32'b0010);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 3'd0, 16'd0);
    step(1);
    checkOutput("t5_clr_tick", 32'(tick), 32'h0);
    checkOutput("t5_clr_sq",   32'(sq),   32'h0);
    checkOutput("t5_clr_busy", 32'(busy), 32'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(1); checkOutput("t5_tick94", 32'(tick), 32'b0000);
    step(1); checkOutput("t5_tick95", 32'(tick), 32'b1100);
    step(2); checkOutput("t5_tick97", 32'(tick), 32'b1101);
    step(1); checkOutput("t5_tick98", 32'(tick), 32'b0010);

    // ch0 back to P=10, pause for 3 cycles at cnt=6
    applyStimulus(4'b1110, 1'b0, 1'b1, 3'd0, 16'd10);
    step(1); checkOutput("t6_busy_99", 32'(busy), 32'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(6);
    applyStimulus(4'b1110, 1'b0, 1'b0, 3'd0, 16'd0);
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      acc = acc | tick[0];
    end
    checkOutput("t6_paused_no_tick", 32'(acc), 32'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    expectPeriod(0, 4, "t6_resume_tick112", seen);

    // async reset mid-period with a pending update on ch1
    step(1);
    applyStimulus(4'b1111, 1'b0, 1'b1, 3'd1, 16'd9);
    step(1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0, 16'd0);
    step(1);
    checkOutput("t6_pre_rst_sq0", 32'(sq[0]), 32'd1);
    checkOutput("t6_pre_rst_busy", 32'(busy), 32'b0010);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_async_rst", 32'({tick, sq, busy}), 32'h0);
    @(negedge clk);
    applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
    rstn = 1'b1;
    expectPeriod(1, 10, "t6_div_restored", seen);

    // write on the wrap edge is deferred one full period
    step(9);
    applyStimulus(4'b0010, 1'b0, 1'b1, 3'd1, 16'd3);
    step(1);
    checkOutput("wrapw_tick20", 32'(tick[1]), 32'd1);
    checkOutput("wrapw_busy20", 32'(busy[1]), 32'd1);
    applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
    expectPeriod(1, 10, "wrapw_old_len30", seen);
    checkOutput("wrapw_busy30", 32'(busy[1]), 32'd0);
    expectPeriod(1, 3, "wrapw_new_len33", seen);

    // clr together with a write: write lands directly as the period
    applyStimulus(4'b0010, 1'b1, 1'b1, 3'd1, 16'd6);
    step(1);
    checkOutput("clrw_busy", 32'(busy), 32'h0);
    checkOutput("clrw_tick", 32'(tick), 32'h0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0, 16'd0);
    expectPeriod(1, 6, "clrw_tick40", seen);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
